// File: rtl/oled_spi_receiver.sv
// SSD1331 4-wire SPI (mode 0) receiver: oversamples CS/SCK/MOSI/DC in the system
// clock domain, assembles MSB-first bytes tagged by DC, and queues them in a FWFT FIFO.
module oled_spi_receiver #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic                            i_CS,
  input  logic                            i_MOSI,
  input  logic                            i_SCK,
  input  logic                            i_DC,
  input  logic                            i_READY,
  output logic                            o_VALID,
  output logic [7:0]                      o_BYTE,
  output logic                            o_IS_DATA,
  output logic [$clog2(FIFO_DEPTH):0]     o_COUNT,
  output logic                            o_BUSY,
  output logic                            o_OVERFLOW,
  output logic                            o_FRAME_ERR
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned FLUSH_CYC = SYNC_STAGES + 1;
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync, dc_sync;
  logic                   cs_d, sck_d;
  logic                   cs_s, sck_s, mosi_s, dc_s;
  logic [FW-1:0]          flush_cnt;
  logic                   flushed, armed;
  logic                   cs_fall_c, cs_rise_c, sck_rise_c;

  logic [0:0]             state_q, state_d;
  logic [2:0]             bitcnt;
  logic [6:0]             shreg;
  logic                   shift_c, push_c;
  logic [8:0]             push_data_c;

  logic [8:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_next_c;
  logic                   full_c, pop_c, wr_en_c;
  logic                   valid_q, overflow_q, frame_err_q, busy_q;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  // Synchronizers plus one edge register; idle values loaded on reset
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_CS};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_MOSI};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], i_DC};
      cs_d      <= cs_s;
      sck_d     <= sck_s;
    end
  end

  // After reset the idle-loaded pipeline would fake a CS fall if the pin is
  // already low; only arm once the pipeline is flushed and CS is seen high.
  assign flushed = (flush_cnt == FW'(FLUSH_CYC));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (!flushed) flush_cnt <= flush_cnt + FW'(1);
      if (flushed && cs_s) armed <= 1'b1;
    end
  end

  assign cs_fall_c  = armed & cs_d & ~cs_s;
  assign cs_rise_c  = ~cs_d & cs_s;
  assign sck_rise_c = ~sck_d & sck_s;

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall_c) state_d = SHIFT;
      SHIFT:   if (cs_rise_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A CS rise in the same cycle as an SCK rise wins and discards the edge
  assign shift_c     = (state_q == SHIFT) & ~cs_rise_c & sck_rise_c;
  assign push_c      = shift_c & (bitcnt == 3'd7);
  assign push_data_c = {dc_s, shreg, mosi_s};

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      bitcnt      <= '0;
      shreg       <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (state_d == SHIFT) & ~cs_s;
      if ((state_q == IDLE) && cs_fall_c) begin
        bitcnt <= '0;
      end else if ((state_q == SHIFT) && cs_rise_c) begin
        if (bitcnt != 3'd0) frame_err_q <= 1'b1;
        bitcnt <= '0;
      end else if (shift_c) begin
        shreg  <= {shreg[5:0], mosi_s};
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  // FWFT byte FIFO; a push when full is accepted only alongside a pop
  assign full_c  = (count == CW'(FIFO_DEPTH));
  assign pop_c   = valid_q & i_READY;
  assign wr_en_c = push_c & (~full_c | pop_c);

  always_comb begin
    count_next_c = count;
    if (wr_en_c && !pop_c)      count_next_c = count + CW'(1);
    else if (!wr_en_c && pop_c) count_next_c = count - CW'(1);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= push_data_c;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
      count   <= count_next_c;
      valid_q <= (count_next_c != '0);
    end
  end

  assign o_VALID     = valid_q;
  assign o_BYTE      = mem[rd_ptr][7:0];
  assign o_IS_DATA   = mem[rd_ptr][8];
  assign o_COUNT     = count;
  assign o_BUSY      = busy_q;
  assign o_OVERFLOW  = overflow_q;
  assign o_FRAME_ERR = frame_err_q;

endmodule
